// File: rtl/banked_sp_ram_pkg.sv
// Shared widths and types for the banked single-port RAM slice.
package banked_sp_ram_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_RAM_DEPTH    = 256;
  localparam int unsigned DEF_NUM_BANKS    = 4;
  localparam int unsigned DEF_NUM_PORTS    = 2;
  localparam int unsigned DEF_LB_RAM_DEPTH = $clog2(DEF_RAM_DEPTH);
  localparam int unsigned DEF_LB_BANKS     = $clog2(DEF_NUM_BANKS);
  localparam int unsigned DEF_BANK_DEPTH   = DEF_RAM_DEPTH / DEF_NUM_BANKS;

  // One requester's access as presented on the bus
  typedef struct packed {
    logic                        wr_en;
    logic [DEF_LB_RAM_DEPTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]   din;
  } port_req_t;

  // Pointer width that stays legal for a single requester
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/banked_sp_ram_if.sv
// Per-port request/response bus of the banked RAM.
interface banked_sp_ram_if
  import banked_sp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int unsigned NUM_PORTS  = DEF_NUM_PORTS
);
  localparam int unsigned LB_RAM_DEPTH = $clog2(RAM_DEPTH);

  logic [NUM_PORTS-1:0]                   req;
  logic [NUM_PORTS-1:0]                   wr_en;
  logic [NUM_PORTS-1:0][LB_RAM_DEPTH-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   din;
  logic [NUM_PORTS-1:0]                   gnt;
  logic [NUM_PORTS-1:0]                   rd_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   dout;

  modport master (output req, wr_en, addr, din, input gnt, rd_valid, dout);
  modport slave  (input req, wr_en, addr, din, output gnt, rd_valid, dout);
endinterface

// File: rtl/banked_sp_ram_rr_arbiter.sv
// Per-bank round-robin arbiter: one-hot grant, priority starts at the pointer.
module rr_arbiter
  import banked_sp_ram_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);
  localparam int unsigned PTR_W = ptr_width(NUM_PORTS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Grant the first requester at or after the pointer, wrapping around
  always_comb begin
    gnt   = '0;
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PTR_W'((32'(ptr) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        sel       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  // Priority moves to the port after the one just granted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= PTR_W'((32'(sel) + 1) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/banked_sp_ram_single_port_ram.sv
// One bank: registered inputs, registered output, two-edge read latency.
module single_port_RAM
  import banked_sp_ram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned RAM_DEPTH  = DEF_BANK_DEPTH,
  localparam int unsigned AW         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic                  en_r;
  logic                  we_r;
  logic [AW-1:0]         addr_r;
  logic [DATA_WIDTH-1:0] din_r;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Input capture; only the strobes need clearing on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_r <= 1'b0;
      we_r <= 1'b0;
    end else begin
      en_r <= en;
      we_r <= we;
    end
    addr_r <= addr;
    din_r  <= din;
  end

  // Array access one edge after capture; a reset edge blocks both write and read
  always_ff @(posedge clk) begin
    if (rst_n && en_r) begin
      if (we_r) mem[addr_r] <= din_r;
      else      dout        <= mem[addr_r];
    end
  end

endmodule

// File: rtl/banked_sp_ram.sv
// Multi-port RAM built from word-interleaved single-port banks.
module banked_sp_ram
  import banked_sp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned NUM_PORTS  = DEF_NUM_PORTS
) (
  input  logic          clk,
  input  logic          rst_n,
  banked_sp_ram_if.slave bus
);
  localparam int unsigned LB_RAM_DEPTH = $clog2(RAM_DEPTH);
  localparam int unsigned LB_BANKS     = $clog2(NUM_BANKS);
  localparam int unsigned BANK_DEPTH   = RAM_DEPTH / NUM_BANKS;
  localparam int unsigned ROW_W        = (LB_RAM_DEPTH > LB_BANKS) ? LB_RAM_DEPTH - LB_BANKS : 1;

  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_req;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_gnt;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_q;
  logic [NUM_PORTS-1:0]                 gnt;
  logic [NUM_PORTS-1:0]                 rd_v1, rd_v2, rd_valid;
  logic [NUM_PORTS-1:0][LB_BANKS-1:0]   rd_b1, rd_b2;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] dout;

  // Route each port's request to the bank its low address bits select; nothing requests in reset
  always_comb begin
    bank_req = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        bank_req[b][p] = rst_n && bus.req[p] && (bus.addr[p][LB_BANKS-1:0] == LB_BANKS'(b));
      end
    end
  end

  // A port is granted when the bank it addresses picked it
  always_comb begin
    gnt = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) gnt |= bank_gnt[b];
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  en;
    logic                  we;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] wdata;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bank_req[b]),
      .gnt   (bank_gnt[b])
    );

    // Steer the granted port's access into this bank
    always_comb begin
      en    = |bank_gnt[b];
      we    = 1'b0;
      row   = '0;
      wdata = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          we    = bus.wr_en[p];
          row   = ROW_W'(bus.addr[p] >> LB_BANKS);
          wdata = bus.din[p];
        end
      end
    end

    single_port_RAM #(.DATA_WIDTH(DATA_WIDTH), .RAM_DEPTH(BANK_DEPTH)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .we    (we),
      .addr  (row),
      .din   (wdata),
      .dout  (bank_q[b])
    );
  end

  // Track which bank each accepted read went to and pick its data up two edges later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v1    <= '0;
      rd_v2    <= '0;
      rd_valid <= '0;
      rd_b1    <= '0;
      rd_b2    <= '0;
      dout     <= '0;
    end else begin
      rd_v1    <= gnt & ~bus.wr_en;
      rd_v2    <= rd_v1;
      rd_valid <= rd_v2;
      rd_b2    <= rd_b1;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rd_b1[p] <= bus.addr[p][LB_BANKS-1:0];
        if (rd_v2[p]) dout[p] <= bank_q[rd_b2[p]];
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rd_valid = rd_valid;
  assign bus.dout     = dout;

endmodule

// File: tb/tb_banked_sp_ram.sv
// Randomised and directed checks of banked_sp_ram against a behavioural model.
module tb_banked_sp_ram;
  import banked_sp_ram_pkg::*;

  localparam int unsigned NP    = DEF_NUM_PORTS;
  localparam int unsigned DW    = DEF_DATA_WIDTH;
  localparam int unsigned DEPTH = DEF_RAM_DEPTH;
  localparam int unsigned NB    = DEF_NUM_BANKS;
  localparam int unsigned LBD   = DEF_LB_RAM_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banked_sp_ram_if #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_PORTS(NP)) bus ();

  banked_sp_ram #(
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (DEPTH),
    .NUM_BANKS  (NB),
    .NUM_PORTS  (NP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_exp_t;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int unsigned   ptr_m [NB];
  rd_exp_t       rq [NP][$];
  logic [DW-1:0] last_dout [NP];
  int unsigned   pw_addr [$];
  logic [DW-1:0] pw_data [$];

  port_req_t       drv [NP];
  logic [NP-1:0]   drv_req;
  logic [NP-1:0]   exp_g;
  logic [NP-1:0]   obs_g;
  int unsigned     cyc;
  int              n_checks;
  int              n_errors;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected grants from the round-robin rule: pointer first, then ascending with wrap
  function automatic logic [NP-1:0] model_grants();
    logic [NP-1:0] g;
    logic          taken;
    int unsigned   p;
    g = '0;
    if (!rst_n) return g;
    for (int unsigned b = 0; b < NB; b++) begin
      taken = 1'b0;
      for (int unsigned k = 0; k < NP; k++) begin
        p = (ptr_m[b] + k) % NP;
        if (!taken && drv_req[p] && ((int'(drv[p].addr) % NB) == b)) begin
          g[p]  = 1'b1;
          taken = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic apply_inputs();
    bus.req = drv_req;
    for (int unsigned p = 0; p < NP; p++) begin
      bus.wr_en[p] = drv[p].wr_en;
      bus.addr[p]  = drv[p].addr;
      bus.din[p]   = drv[p].din;
    end
  endtask

  task automatic set_port(input int unsigned p, input logic r, input logic we,
                          input int unsigned a, input logic [DW-1:0] d);
    drv_req[p]   = r;
    drv[p].wr_en = we;
    drv[p].addr  = LBD'(a);
    drv[p].din   = d;
  endtask

  task automatic idle_all();
    for (int unsigned p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, 0, '0);
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic step();
    int unsigned a;
    apply_inputs();
    @(negedge clk);
    exp_g = model_grants();
    obs_g = bus.gnt;
    check_eq("gnt", bus.gnt, exp_g);
    for (int unsigned p = 0; p < NP; p++) begin
      if (rq[p].size() > 0 && rq[p][0].due == cyc) begin
        check_eq($sformatf("rd_valid%0d", p), bus.rd_valid[p], 1);
        check_eq($sformatf("dout%0d", p), bus.dout[p], rq[p][0].data);
        last_dout[p] = rq[p][0].data;
        void'(rq[p].pop_front());
      end else begin
        check_eq($sformatf("rd_valid%0d_idle", p), bus.rd_valid[p], 0);
        check_eq($sformatf("dout%0d_hold", p), bus.dout[p], last_dout[p]);
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      pw_addr.delete();
      pw_data.delete();
      for (int unsigned b = 0; b < NB; b++) ptr_m[b] = 0;
      for (int unsigned p = 0; p < NP; p++) begin
        rq[p].delete();
        last_dout[p] = '0;
      end
    end else begin
      foreach (pw_addr[i]) mem_m[pw_addr[i]] = pw_data[i];
      pw_addr.delete();
      pw_data.delete();
      for (int unsigned p = 0; p < NP; p++) begin
        if (exp_g[p]) begin
          a = int'(drv[p].addr);
          ptr_m[a % NB] = (p + 1) % NP;
          if (drv[p].wr_en) begin
            pw_addr.push_back(a);
            pw_data.push_back(drv[p].din);
          end else begin
            rq[p].push_back('{due: cyc + 2, data: mem_m[a]});
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle_steps(input int unsigned n);
    idle_all();
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    exp_g    = '0;
    obs_g    = '0;
    for (int unsigned b = 0; b < NB; b++) ptr_m[b] = 0;
    for (int unsigned p = 0; p < NP; p++) last_dout[p] = '0;
    idle_all();
    rst_n = 1'b0;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a request presented: gnt must stay low
    set_port(0, 1'b1, 1'b0, 3, '0);
    step();
    step();
    rst_n = 1'b1;

    // Preload every word: even addresses from port 0, odd from port 1 (never the same bank)
    for (int unsigned i = 0; i < DEPTH; i += 2) begin
      set_port(0, 1'b1, 1'b1, i,     DW'($urandom));
      set_port(1, 1'b1, 1'b1, i + 1, DW'($urandom));
      step();
    end
    idle_steps(2);

    // Write then read-back on port 0
    idle_all();
    set_port(0, 1'b1, 1'b1, 5, 8'hA5);
    step();
    set_port(0, 1'b1, 1'b0, 5, '0);
    step();
    idle_steps(3);

    // Reset zeroes the bank pointers
    rst_n = 1'b0;
    idle_steps(2);
    rst_n = 1'b1;

    // Same-bank collision: port 0 first, port 1 holds and follows
    set_port(0, 1'b1, 1'b0, 4, '0);
    set_port(1, 1'b1, 1'b0, 8, '0);
    step();
    set_port(0, 1'b0, 1'b0, 0, '0);
    step();
    idle_steps(3);

    // Different banks granted together
    set_port(0, 1'b1, 1'b0, 1, '0);
    set_port(1, 1'b1, 1'b0, 2, '0);
    step();
    idle_steps(3);

    // Continuous contention on bank 3 must alternate
    set_port(0, 1'b1, 1'b0, 3, '0);
    set_port(1, 1'b1, 1'b0, 7, '0);
    for (int unsigned k = 0; k < 6; k++) begin
      step();
      check_eq($sformatf("rr_seq%0d", k), obs_g, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle_steps(3);

    // Read in flight when reset arrives is dropped; contents survive
    set_port(0, 1'b1, 1'b0, 7, '0);
    step();
    rst_n = 1'b0;
    idle_steps(2);
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 7, '0);
    step();
    idle_steps(3);

    // Random traffic; a port not granted keeps its request unchanged
    for (int unsigned n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      for (int unsigned p = 0; p < NP; p++) begin
        if (!(drv_req[p] && !exp_g[p])) begin
          set_port(p, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 15),
                   DW'($urandom));
        end
      end
      step();
    end
    rst_n = 1'b1;
    idle_steps(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/banked_sp_ram.md
BANKED_SP_RAM -- requirements
Module: banked_sp_RAM

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter RAM_DEPTH, default 256, total words across all banks; power of two.
REQ-003 Parameter NUM_BANKS, default 4, interleaved banks; power of two, at least 2, at most RAM_DEPTH.
REQ-004 Parameter NUM_PORTS, default 2, independent requesters; at least 1.
REQ-005 Derived: LB_RAM_DEPTH = $clog2(RAM_DEPTH); LB_BANKS = $clog2(NUM_BANKS); BANK_DEPTH = RAM_DEPTH/NUM_BANKS.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 req  input  [NUM_PORTS]  per-port access request.
REQ-009 wr_en  input  [NUM_PORTS]  per-port access type: 1 = write, 0 = read.
REQ-010 addr  input  [NUM_PORTS][LB_RAM_DEPTH]  per-port word address.
REQ-011 din  input  [NUM_PORTS][DATA_WIDTH]  per-port write data.
REQ-012 gnt  output  [NUM_PORTS]  request accepted this cycle.
REQ-013 rd_valid  output  [NUM_PORTS]  dout of that port carries read data this cycle.
REQ-014 dout  output  [NUM_PORTS][DATA_WIDTH]  per-port read data.

Function
REQ-015 Bank select = addr[LB_BANKS-1:0]; row within bank = addr[LB_RAM_DEPTH-1:LB_BANKS].
REQ-016 gnt is combinational from req, wr_en, addr and arbiter state; a request is accepted on a clock edge where req and gnt are both high.
REQ-017 Each bank accepts at most one request per cycle; ports targeting different banks are granted in the same cycle.
REQ-018 Per-bank round-robin: the highest-priority port is the bank's pointer value, then ascending port index with wrap.
REQ-019 On a grant, the bank's pointer advances to (granted port + 1) mod NUM_PORTS; without a grant the pointer holds.
REQ-020 A port not granted sees gnt=0 and holds req, wr_en, addr and din stable until granted; any change counts as a new request.
REQ-021 Accepted write: din is stored at the addressed word at the end of the cycle following acceptance; no rd_valid is generated.
REQ-022 Accepted read: rd_valid is high for exactly one cycle, 2 cycles after acceptance (accept at edge N, rd_valid high in cycle N+2), with dout = word content.
REQ-023 Read-after-write ordering: a read accepted one or more cycles after an accepted write to the same address returns the new data.
REQ-024 Same-cycle write and read to the same bank: arbitration serialises them; a read granted later returns the written data.
REQ-025 Reads issued back-to-back from one port return in issue order, one per cycle, at full throughput.
REQ-026 When rd_valid is low, dout holds its last value; it is not cleared.
REQ-027 NUM_PORTS = 1: gnt equals req; every request is accepted with no stall.

Reset
REQ-028 While rst_n is low at a rising edge: all bank pointers reset to 0, the rd_valid pipeline clears, and no write commits.
REQ-029 Outputs during and after reset: gnt = 0 while rst_n is low; rd_valid = 0; dout = 0.
REQ-030 Reset mid-operation: in-flight reads are dropped and never produce rd_valid; RAM contents are not reset and are retained.

Structure
REQ-031 A shared package holds the derived-width localparams and a typedef for the per-port request bundle.
REQ-032 One sub-module, rr_arbiter (NUM_PORTS-wide request in, one-hot grant out, pointer state), is instantiated once per bank.
REQ-033 Bank storage uses one single_port_RAM instance per bank (DATA_WIDTH, BANK_DEPTH): registered inputs, registered output, 2-cycle read latency.

Verification
REQ-034 Reset, then port0 writes 0xA5 to addr 5; port0 reads addr 5 one cycle later -> gnt=1 each cycle, rd_valid[0]=1 two cycles after the read accept, dout[0]=0xA5.
REQ-035 Ports 0 and 1 read addr 4 and addr 8 (same bank 0) in the same cycle with pointer 0 -> port0 granted first, port1 granted the next cycle, rd_valid returns on consecutive cycles.
REQ-036 Ports 0 and 1 read addr 1 and addr 2 (banks 1 and 2) in the same cycle -> both granted, both rd_valid in the same cycle 2 cycles later.
REQ-037 Both ports request bank 3 continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; no port is starved.
REQ-038 Read of addr 7 accepted, rst_n pulled low the next cycle -> rd_valid never asserts, dout=0; after reset a read of addr 7 returns the previously written value.
